mem_arbiter: RTL and testbench

Sequencer and arbiter sitting in front of the single-ported data memory (`dmem`: `we`, `re`, `HSEL`, `a`, `wd`, `rd`, `Valid`). It shares the memory among three requesters: MMU table walker, data cache, and instruction cache. It converts each granted request into either a single-word access or an aligned cache-line burst, and it returns read data beat by beat.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/arb_pick.sv | 15 +
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: requester indices, FSM state type and default line size for the dmem arbiter
package mem_arb_pkg;
  localparam int REQ_WALK = 0;
  localparam int REQ_DC = 1;
  localparam int REQ_IC = 2;
  localparam int BLOCKSIZE_DEF = 4;
  typedef enum logic {IDLE, XFER} arbstate_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select, walker first, then dcache/icache by last-served pointer
//   req     in  request vector (0 walker, 1 dcache, 2 icache)
//   last_ic in  1 = icache was served last, so dcache wins a dcache/icache tie
//   win     out one-hot winner, zero when nothing requests
module arb_pick import mem_arb_pkg::*; #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic            last_ic,
  output logic [NREQ-1:0] win
);
  assign win = req[REQ_WALK] ? NREQ'(1) << REQ_WALK :
               (req[REQ_DC] && (!req[REQ_IC] || last_ic)) ? NREQ'(1) << REQ_DC :
               req[REQ_IC] ? NREQ'(1) << REQ_IC : '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares single-ported dmem among walker, dcache and icache; single words or aligned line bursts
//   Req/ReqWE/ReqSingle/ReqAddr/ReqWD  in   per-requester request, direction, size, byte address, write data
//   Gnt/Done                           out  one-hot owner, final-beat pulse
//   RD/RDValid/BeatIdx                 out  read data pass-through, read beat accepted, word offset in line
//   MemRE/MemWE/MemHSEL/MemA/MemWD     out  memory strobes, address, write data
//   MemRD/MemValid                     in   memory read data, access completed
//   ARB_ROUND_ROBIN_EN: when defined, dcache/icache ties alternate; otherwise dcache beats icache
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int BLOCKSIZE = BLOCKSIZE_DEF,
  parameter int NREQ = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              Req,
  input  logic [NREQ-1:0]              ReqWE,
  input  logic [NREQ-1:0]              ReqSingle,
  input  logic [NREQ-1:0][31:0]        ReqAddr,
  input  logic [NREQ-1:0][31:0]        ReqWD,
  output logic [NREQ-1:0]              Gnt,
  output logic [NREQ-1:0]              Done,
  output logic [31:0]                  RD,
  output logic                         RDValid,
  output logic [$clog2(BLOCKSIZE)-1:0] BeatIdx,
  output logic                         MemRE,
  output logic                         MemWE,
  output logic                         MemHSEL,
  output logic [31:0]                  MemA,
  output logic [31:0]                  MemWD,
  input  logic [31:0]                  MemRD,
  input  logic                         MemValid
);
  localparam int BW = $clog2(BLOCKSIZE);
  arbstate_t state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, win;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [1:0] own;
  logic xfer, beat, last, last_ic;
  logic [31:0] addr;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_ic_q, last_ic_d;
  assign last_ic_d = (last && gnt_q[REQ_IC]) ? 1'b1 : (last && gnt_q[REQ_DC]) ? 1'b0 : last_ic_q;
  always_ff @(posedge clk)
    if (reset) last_ic_q <= 1'b1;
    else last_ic_q <= last_ic_d;
  assign last_ic = last_ic_q;
`else
  assign last_ic = 1'b1;
`endif
  arb_pick #(.NREQ(NREQ)) u_pick (.req(Req), .last_ic(last_ic), .win(win));
  assign own  = gnt_q[REQ_IC] ? 2'd2 : gnt_q[REQ_DC] ? 2'd1 : 2'd0;
  assign xfer = state_q == XFER;
  assign beat = xfer && MemValid;
  assign last = beat && (ReqSingle[own] || cnt_q == BW'(BLOCKSIZE - 1));
  assign addr = ReqAddr[own];
  always_comb begin
    state_d = xfer ? (last ? IDLE : XFER) : (|Req ? XFER : IDLE);
    gnt_d = xfer ? (last ? '0 : gnt_q) : win;
    cnt_d = (!xfer || last) ? '0 : cnt_q + BW'(beat);
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
    end
  assign Gnt = gnt_q;
  assign Done = last ? gnt_q : '0;
  assign BeatIdx = cnt_q;
  assign RD = MemRD;
  assign RDValid = beat && !ReqWE[own];
  assign MemHSEL = xfer;
  assign MemWE = xfer && ReqWE[own];
  assign MemRE = xfer && !ReqWE[own];
  assign MemWD = xfer ? ReqWD[own] : '0;
  // bursts ignore the low line-offset bits so every line starts at word 0
  assign MemA = !xfer ? '0 : ReqSingle[own] ? addr & ~32'h3 :
                (addr & ~32'(BLOCKSIZE * 4 - 1)) | {{(30 - BW){1'b0}}, cnt_q, 2'b00};
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus checked against a transaction-level arbiter model
module tb_mem_arbiter;
  localparam int BS = 4;
  localparam int BW = $clog2(BS);
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [2:0] Req, ReqWE, ReqSingle, Gnt, Done;
  logic [2:0][31:0] ReqAddr, ReqWD;
  logic [31:0] RD, MemA, MemWD, MemRD;
  logic RDValid, MemRE, MemWE, MemHSEL, MemValid;
  logic [BW-1:0] BeatIdx;
  mem_arbiter #(.BLOCKSIZE(BS), .NREQ(3)) dut (
    .clk(clk), .reset(reset), .Req(Req), .ReqWE(ReqWE), .ReqSingle(ReqSingle),
    .ReqAddr(ReqAddr), .ReqWD(ReqWD), .Gnt(Gnt), .Done(Done), .RD(RD), .RDValid(RDValid),
    .BeatIdx(BeatIdx), .MemRE(MemRE), .MemWE(MemWE), .MemHSEL(MemHSEL), .MemA(MemA),
    .MemWD(MemWD), .MemRD(MemRD), .MemValid(MemValid)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  bit act[3], drp[3], we[3], sg[3];
  logic [31:0] ad[3], wd[3];
  bit mv, rst_in;
  logic [31:0] mrd = '0;
  int own = -1, beat = 0, last_srv = 2;
  logic [2:0] prev_g = '0;
  logic [31:0] log_a[$];
  logic [2:0] log_g[$];
  int n_rdv;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit rq(int i);
    return act[i] && !drp[i];
  endfunction
  // walker always first; a dcache/icache tie goes to whoever was not served last (or dcache if fixed)
  function automatic int pick();
    if (rq(0)) return 0;
    if (rq(1) && rq(2)) return RR ? (last_srv == 2 ? 1 : 2) : 1;
    if (rq(1)) return 1;
    if (rq(2)) return 2;
    return -1;
  endfunction
  task automatic start(int i, bit w, bit s, logic [31:0] a);
    act[i] = 1'b1;
    drp[i] = 1'b0;
    we[i] = w;
    sg[i] = s;
    ad[i] = a;
  endtask
  task automatic clr();
    log_a.delete();
    log_g.delete();
    n_rdv = 0;
  endtask
  task automatic step();
    bit xf, ev;
    int o;
    logic [2:0] eg, ed;
    logic [31:0] ea;
    for (int i = 0; i < 3; i++) begin
      wd[i] = $urandom;
      Req[i] = rq(i);
      ReqWE[i] = we[i];
      ReqSingle[i] = sg[i];
      ReqAddr[i] = ad[i];
      ReqWD[i] = wd[i];
    end
    MemValid = mv;
    MemRD = mrd;
    reset = rst_in;
    #1;
    xf = own >= 0;
    o = xf ? own : 0;
    eg = xf ? 3'(1 << o) : 3'b000;
    ev = xf && mv;
    ed = (ev && (sg[o] || beat == BS - 1)) ? eg : 3'b000;
    ea = !xf ? 32'h0 : sg[o] ? ad[o] & ~32'h3 : ad[o] - ad[o] % (BS * 4) + 32'(beat * 4);
    chk("Gnt", Gnt, eg);
    chk("Done", Done, ed);
    chk("MemHSEL", MemHSEL, xf);
    chk("MemWE", MemWE, xf && we[o]);
    chk("MemRE", MemRE, xf && !we[o]);
    chk("MemA", MemA, ea);
    chk("MemWD", MemWD, xf ? wd[o] : 32'h0);
    chk("RDValid", RDValid, ev && !we[o]);
    chk("RD", RD, mrd);
    chk("BeatIdx", BeatIdx, beat);
    if (Gnt != 0 && prev_g == 0) log_g.push_back(Gnt);
    prev_g = Gnt;
    if (MemHSEL && MemValid) log_a.push_back(MemA);
    if (RDValid) n_rdv++;
    @(posedge clk);
    if (rst_in) begin
      own = -1;
      beat = 0;
      last_srv = 2;
      for (int i = 0; i < 3; i++) begin
        act[i] = 1'b0;
        drp[i] = 1'b0;
      end
    end else if (own < 0) begin
      own = pick();
      beat = 0;
    end else if (mv) begin
      if (sg[own] || beat == BS - 1) begin
        if (own > 0) last_srv = own;
        act[own] = 1'b0;
        drp[own] = 1'b0;
        own = -1;
        beat = 0;
      end else beat++;
    end
    @(negedge clk);
  endtask
  task automatic run_idle(int max);
    int k = 0;
    while ((act[0] || act[1] || act[2] || own >= 0) && k < max) begin
      step();
      k++;
    end
    chk("drain", 32'(act[0] || act[1] || act[2] || own >= 0), 32'h0);
    step();
  endtask
  initial begin
    logic [2:0] exp_g[2];
    reset = 1'b1;
    Req = '0; ReqWE = '0; ReqSingle = '0; ReqAddr = '0; ReqWD = '0;
    MemValid = 1'b0; MemRD = '0;
    rst_in = 1'b0; mv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    // walker single read
    clr();
    mv = 1'b1; mrd = 32'hDEADBEEF;
    start(0, 1'b0, 1'b1, 32'h0000_0104);
    run_idle(10);
    chk("single_gnt", log_g[0], 3'b001);
    chk("single_a", log_a[0], 32'h104);
    chk("single_rdv", n_rdv, 1);
    // dcache line read
    clr();
    start(1, 1'b0, 1'b0, 32'h0000_201C);
    run_idle(20);
    chk("line_n", log_a.size(), 4);
    for (int i = 0; i < 4; i++) chk("line_a", log_a[i], 32'h2010 + 32'(i * 4));
    chk("line_rdv", n_rdv, 4);
    // icache line write with a 3-cycle stall on beat 2
    clr();
    start(2, 1'b1, 1'b0, 32'h0000_3004);
    repeat (3) step();
    mv = 1'b0;
    repeat (3) step();
    chk("stall_beat", BeatIdx, 2);
    chk("stall_a", MemA, 32'h3008);
    mv = 1'b1;
    run_idle(20);
    chk("stall_n", log_a.size(), 4);
    chk("stall_a3", log_a[3], 32'h300C);
    chk("stall_rdv", n_rdv, 0);
    // all three requesters together
    clr();
    start(0, 1'b0, 1'b1, 32'h100);
    start(1, 1'b0, 1'b1, 32'h200);
    start(2, 1'b1, 1'b1, 32'h300);
    run_idle(40);
    chk("sim_n", log_g.size(), 3);
    chk("sim_g0", log_g[0], 3'b001);
    chk("sim_g1", log_g[1], 3'b010);
    chk("sim_g2", log_g[2], 3'b100);
    // after a dcache-only transfer, a dcache/icache tie goes to icache only under round robin
    start(1, 1'b0, 1'b1, 32'h500);
    run_idle(10);
    clr();
    start(1, 1'b0, 1'b1, 32'h600);
    start(2, 1'b0, 1'b1, 32'h700);
    run_idle(20);
    exp_g[0] = RR ? 3'b100 : 3'b010;
    exp_g[1] = RR ? 3'b010 : 3'b100;
    chk("tie_g0", log_g[0], exp_g[0]);
    chk("tie_g1", log_g[1], exp_g[1]);
    // reset during beat 1 of a dcache burst
    start(1, 1'b0, 1'b0, 32'h4000);
    repeat (2) step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    step();
    clr();
    start(2, 1'b0, 1'b1, 32'h6000);
    run_idle(10);
    chk("rst_g", log_g[0], 3'b100);
    chk("rst_n", log_g.size(), 1);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!act[i] && own != i && $urandom_range(3) == 0)
          start(i, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
        if (act[i] && own == i && $urandom_range(15) == 0) drp[i] = 1'b1;
      end
      mv = $urandom_range(3) != 0;
      mrd = $urandom;
      rst_in = $urandom_range(199) == 0;
      step();
    end
    rst_in = 1'b0;
    mv = 1'b1;
    run_idle(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
